// File: rtl/uart_io_ctrl.sv
// Sequences exec-stage UART requests onto a byte-wide TX channel and an RX byte FIFO.
// A write is sent as 1 or 4 little-endian bytes; a read is assembled from 1 or 4 buffered bytes.
module uart_io_ctrl #(
  parameter int RX_DEPTH = 16
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      wenable,
  input  logic [31:0]               wd,
  input  logic                      wword,
  output logic                      wdone,
  input  logic                      renable,
  input  logic                      rword,
  output logic                      rdone,
  output logic [31:0]               rd,
  output logic [7:0]                tx_data,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  input  logic [7:0]                rx_data,
  input  logic                      rx_valid,
  output logic                      rx_overrun,
  output logic [$clog2(RX_DEPTH):0] rx_count
);
  localparam int AW = $clog2(RX_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic { T_IDLE, T_SEND } tx_state_t;
  typedef enum logic { R_IDLE, R_COLLECT } rx_state_t;

  // ---------------- TX ----------------
  tx_state_t   t_state, t_next;
  logic [31:0] t_sh;
  logic [2:0]  t_rem;
  logic        t_fire, t_last;

  assign tx_valid = (t_state == T_SEND);
  assign tx_data  = t_sh[7:0];
  assign t_fire   = tx_valid && tx_ready;
  assign t_last   = t_fire && (t_rem == 3'd1);

  always_ff @(posedge clk) begin
    if (!rstn) t_state <= T_IDLE;
    else       t_state <= t_next;
  end

  always_comb begin
    t_next = t_state;
    case (t_state)
      T_IDLE:  if (wenable) t_next = T_SEND;
      T_SEND:  if (t_last)  t_next = T_IDLE;
      default: t_next = T_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      t_sh  <= '0;
      t_rem <= '0;
      wdone <= 1'b0;
    end else begin
      wdone <= t_last;
      if (t_state == T_IDLE && wenable) begin
        t_sh  <= wd;
        t_rem <= wword ? 3'd4 : 3'd1;
      end else if (t_fire) begin
        t_sh  <= t_sh >> 8;
        t_rem <= t_rem - 3'd1;
      end
    end
  end

  // ---------------- RX FIFO ----------------
  rx_state_t     r_state, r_next;
  logic [7:0]    mem [RX_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          full, empty, push, pop;
  logic [7:0]    rd_byte;

  assign full    = (rx_count == CW'(RX_DEPTH));
  assign empty   = (rx_count == '0);
  assign pop     = (r_state == R_COLLECT) && !empty;
  // A pop on the same edge frees a slot, so a push at full is still accepted.
  assign push    = rx_valid && (!full || pop);
  assign rd_byte = mem[rptr];

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= rx_data;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wptr       <= '0;
      rptr       <= '0;
      rx_count   <= '0;
      rx_overrun <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (push && !pop)      rx_count <= rx_count + 1'b1;
      else if (pop && !push) rx_count <= rx_count - 1'b1;
      if (rx_valid && !push) rx_overrun <= 1'b1;
    end
  end

  // ---------------- RX assembly ----------------
  logic        r_word, r_last;
  logic [1:0]  r_got;
  logic [23:0] r_asm;

  assign r_last = pop && (!r_word || r_got == 2'd3);

  always_ff @(posedge clk) begin
    if (!rstn) r_state <= R_IDLE;
    else       r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:    if (renable) r_next = R_COLLECT;
      R_COLLECT: if (r_last)  r_next = R_IDLE;
      default:   r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_word <= 1'b0;
      r_got  <= '0;
      r_asm  <= '0;
      rd     <= '0;
      rdone  <= 1'b0;
    end else begin
      rdone <= r_last;
      if (r_state == R_IDLE && renable) begin
        r_word <= rword;
        r_got  <= '0;
        r_asm  <= '0;
      end else if (pop) begin
        r_got <= r_got + 2'd1;
        case (r_got)
          2'd0:    r_asm[7:0]   <= rd_byte;
          2'd1:    r_asm[15:8]  <= rd_byte;
          2'd2:    r_asm[23:16] <= rd_byte;
          default: ;
        endcase
        if (r_last) rd <= r_word ? {rd_byte, r_asm} : {24'h0, rd_byte};
      end
    end
  end
endmodule

// File: tb/tb_uart_io_ctrl.sv
// Directed bench for uart_io_ctrl: queue-level model checked every cycle plus literal expectations.
module tb_uart_io_ctrl;
  localparam int RX_DEPTH = 16;

  logic        clk = 0, rstn = 0;
  logic        wenable = 0, wword = 0, renable = 0, rword = 0;
  logic [31:0] wd = '0;
  logic        tx_ready = 0, rx_valid = 0;
  logic [7:0]  rx_data = '0;
  logic        wdone, rdone, tx_valid, rx_overrun;
  logic [31:0] rd;
  logic [7:0]  tx_data;
  logic [$clog2(RX_DEPTH):0] rx_count;

  uart_io_ctrl #(.RX_DEPTH(RX_DEPTH)) dut (
    .clk(clk), .rstn(rstn),
    .wenable(wenable), .wd(wd), .wword(wword), .wdone(wdone),
    .renable(renable), .rword(rword), .rdone(rdone), .rd(rd),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_overrun(rx_overrun), .rx_count(rx_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_fail = 0, cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // ---- model: byte queues for TX and the RX FIFO, counters for read assembly ----
  logic [7:0]  m_tx_q[$];
  logic [7:0]  m_fifo[$];
  logic        m_wdone = 0, m_rdone = 0, m_ovr = 0, m_live = 0;
  logic [31:0] m_rd = '0, m_acc = '0;
  int          m_need = 0, m_got = 0;

  always @(posedge clk) begin
    if (!rstn) begin
      m_tx_q.delete(); m_fifo.delete();
      m_wdone = 0; m_rdone = 0; m_ovr = 0; m_rd = '0; m_acc = '0;
      m_need = 0; m_got = 0; m_live = 1;
    end else if (m_live) begin
      bit idle_pre;
      m_wdone = 0; m_rdone = 0;
      if (m_tx_q.size() > 0) begin
        if (tx_ready) begin
          void'(m_tx_q.pop_front());
          if (m_tx_q.size() == 0) m_wdone = 1;
        end
      end else if (wenable) begin
        for (int i = 0; i < (wword ? 4 : 1); i++) m_tx_q.push_back(wd[8*i +: 8]);
      end
      idle_pre = (m_need == 0);
      if (!idle_pre && m_fifo.size() > 0) begin
        m_acc[8*m_got +: 8] = m_fifo.pop_front();
        m_got++;
        if (m_got == m_need) begin
          m_rd = m_acc; m_rdone = 1; m_need = 0;
        end
      end
      if (rx_valid) begin
        if (m_fifo.size() < RX_DEPTH) m_fifo.push_back(rx_data);
        else m_ovr = 1;
      end
      if (idle_pre && renable) begin
        m_need = rword ? 4 : 1; m_got = 0; m_acc = '0;
      end
    end
  end

  // ---- compare + event log, on the falling edge ----
  logic [7:0] hs_log[$];
  int hs_cyc = 0, n_wdone = 0, wdone_cyc = 0, n_rdone = 0, rdone_cyc = 0;

  always @(negedge clk) begin
    if (m_live) begin
      chk("tx_valid", 32'(tx_valid), 32'(m_tx_q.size() > 0));
      if (m_tx_q.size() > 0) chk("tx_data", 32'(tx_data), 32'(m_tx_q[0]));
      chk("wdone", 32'(wdone), 32'(m_wdone));
      chk("rdone", 32'(rdone), 32'(m_rdone));
      chk("rd", rd, m_rd);
      chk("rx_count", 32'(rx_count), m_fifo.size());
      chk("rx_overrun", 32'(rx_overrun), 32'(m_ovr));
    end
    if (tx_valid && tx_ready) begin hs_log.push_back(tx_data); hs_cyc = cyc; end
    if (wdone) begin n_wdone++; wdone_cyc = cyc; end
    if (rdone) begin n_rdone++; rdone_cyc = cyc; end
  end

  // ---- stimulus helpers (inputs change 1 time unit after the rising edge) ----
  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push_byte(input logic [7:0] b);
    rx_valid = 1; rx_data = b; tick(); rx_valid = 0;
  endtask

  task automatic read_req(input logic w, output int c0);
    renable = 1; rword = w; c0 = cyc; tick(); renable = 0;
  endtask

  task automatic write_req(input logic w, input logic [31:0] d, output int c0);
    wenable = 1; wword = w; wd = d; c0 = cyc; tick(); wenable = 0;
  endtask

  task automatic wait_rd(input int n0);
    for (int i = 0; i < 60 && n_rdone == n0; i++) tick();
    chk("rdone_arrived", 32'(n_rdone > n0), 32'd1);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, w0, r0;
    logic [7:0]  exp_tx[4];
    logic [31:0] exp_w[4];

    rstn = 0; tick(3); rstn = 1; tick();
    chk("rst_tx_valid", 32'(tx_valid), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_rd", rd, 0);
    chk("rst_rx_count", 32'(rx_count), 0);
    chk("rst_overrun", 32'(rx_overrun), 0);
    chk("rst_done", 32'({wdone, rdone}), 0);

    // word write with two stall cycles before each byte
    hs_log.delete(); w0 = n_wdone; tx_ready = 0;
    write_req(1, 32'h11223344, c0);
    for (int i = 0; i < 4; i++) begin
      tick(2); tx_ready = 1; tick(); tx_ready = 0;
    end
    tick(3);
    exp_tx[0] = 8'h44; exp_tx[1] = 8'h33; exp_tx[2] = 8'h22; exp_tx[3] = 8'h11;
    chk("t1_nbytes", hs_log.size(), 4);
    for (int i = 0; i < 4 && i < hs_log.size(); i++) chk("t1_byte", 32'(hs_log[i]), 32'(exp_tx[i]));
    chk("t1_one_wdone", n_wdone, w0 + 1);
    chk("t1_wdone_cycle", wdone_cyc, hs_cyc + 1);

    // byte read waiting on an empty FIFO
    r0 = n_rdone;
    read_req(0, c0);
    tick(10);
    chk("t2_no_early_rdone", n_rdone, r0);
    push_byte(8'hA5);
    tick(4);
    chk("t2_one_rdone", n_rdone, r0 + 1);
    chk("t2_rd", rd, 32'h000000A5);
    chk("t2_count", 32'(rx_count), 0);

    // buffered word read latency
    for (int b = 1; b <= 4; b++) push_byte(8'(b));
    tick();
    r0 = n_rdone;
    read_req(1, c0);
    wait_rd(r0);
    chk("t3_latency", rdone_cyc - c0, 5);
    chk("t3_rd", rd, 32'h04030201);

    // overflow: 17 bytes into a 16-deep FIFO
    for (int b = 0; b < 17; b++) push_byte(8'(b));
    tick();
    chk("t4_overrun", 32'(rx_overrun), 1);
    chk("t4_count", 32'(rx_count), 16);
    exp_w[0] = 32'h03020100; exp_w[1] = 32'h07060504;
    exp_w[2] = 32'h0B0A0908; exp_w[3] = 32'h0F0E0D0C;
    for (int j = 0; j < 4; j++) begin
      r0 = n_rdone; read_req(1, c0); wait_rd(r0);
      chk("t4_rd", rd, exp_w[j]);
    end
    chk("t4_drained", 32'(rx_count), 0);

    // full FIFO, push on a pop edge is accepted
    rstn = 0; tick(2); rstn = 1; tick();
    for (int b = 0; b < 16; b++) push_byte(8'(8'h20 + b));
    chk("t5_full", 32'(rx_count), 16);
    r0 = n_rdone;
    read_req(1, c0);
    rx_valid = 1; rx_data = 8'h30; tick(); rx_valid = 0;
    chk("t5_count_held", 32'(rx_count), 16);
    chk("t5_no_overrun", 32'(rx_overrun), 0);
    wait_rd(r0);
    chk("t5_rd0", rd, 32'h23222120);
    exp_w[0] = 32'h27262524; exp_w[1] = 32'h2B2A2928; exp_w[2] = 32'h2F2E2D2C;
    for (int j = 0; j < 3; j++) begin
      r0 = n_rdone; read_req(1, c0); wait_rd(r0);
      chk("t5_rd", rd, exp_w[j]);
    end
    r0 = n_rdone; read_req(0, c0); wait_rd(r0);
    chk("t5_rd_last", rd, 32'h00000030);
    chk("t5_overrun_end", 32'(rx_overrun), 0);

    // reset in the middle of a word write and a word read
    push_byte(8'hAA); push_byte(8'hBB);
    w0 = n_wdone; r0 = n_rdone; tx_ready = 1;
    wenable = 1; wword = 1; wd = 32'hDEADBEEF;
    renable = 1; rword = 1;
    tick(); wenable = 0; renable = 0;
    tick(2);
    rstn = 0; tx_ready = 0; tick(2); rstn = 1; tick(3);
    chk("t6_no_wdone", n_wdone, w0);
    chk("t6_no_rdone", n_rdone, r0);
    chk("t6_tx_valid", 32'(tx_valid), 0);
    chk("t6_tx_data", 32'(tx_data), 0);
    chk("t6_rd", rd, 0);
    chk("t6_count", 32'(rx_count), 0);
    hs_log.delete(); tx_ready = 1;
    write_req(0, 32'h0000007E, c0);
    tick(4);
    chk("t6_nbytes", hs_log.size(), 1);
    if (hs_log.size() > 0) chk("t6_byte", 32'(hs_log[0]), 32'h7E);
    chk("t6_wdone_count", n_wdone, w0 + 1);
    chk("t6_wdone_latency", wdone_cyc - c0, 2);
    push_byte(8'h5A);
    r0 = n_rdone; read_req(0, c0); wait_rd(r0);
    chk("t6_rd_fresh", rd, 32'h0000005A);
    chk("t6_rd_latency", rdone_cyc - c0, 2);

    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
